// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshake, stall hold, branch flush and an optional two-entry skid buffer.
// The head register M drives the outputs. The skid register S exists only
// logically when SKID=1; with SKID=0 the state machine never enters FULL.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 1,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // EMPTY: nothing held; BUSY: M valid; FULL: M and S valid (SKID=1 only)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] m_data_reg, m_data_next;
  logic [CTRL_W-1:0] m_ctrl_reg, m_ctrl_next;
  logic [DATA_W-1:0] s_data_reg, s_data_next;
  logic [CTRL_W-1:0] s_ctrl_reg, s_ctrl_next;
  logic              in_ready_reg;
  logic [1:0]        occupancy_reg, occupancy_next;

  logic m_valid;
  logic go;
  logic out_xfer;
  logic in_xfer;

  assign m_valid   = (state_reg != EMPTY);
  assign go        = out_ready & ~stall;
  // flush masks the head beat in the same cycle, before the state clears
  assign out_valid = m_valid & ~flush;
  assign out_xfer  = out_valid & go;
  // With the skid buffer in_ready is a flop, so there is no path from
  // out_ready/stall to in_ready; without it the ready path is combinational.
  assign in_ready  = (SKID != 0) ? in_ready_reg : (~m_valid | go);
  assign in_xfer   = in_valid & in_ready & ~flush;

  assign out_data  = m_data_reg;
  // bubbles never carry write enables downstream
  assign out_ctrl  = out_valid ? m_ctrl_reg : '0;
  assign occupancy = occupancy_reg;

  // Next-state and storage update: flush first, then the handshake moves
  always_comb begin
    state_next  = state_reg;
    m_data_next = m_data_reg;
    m_ctrl_next = m_ctrl_reg;
    s_data_next = s_data_reg;
    s_ctrl_next = s_ctrl_reg;
    if (flush) begin
      // kill every held beat; data bits are left as don't-care
      state_next  = EMPTY;
      m_ctrl_next = '0;
      s_ctrl_next = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next  = BUSY;
            m_data_next = in_data;
            m_ctrl_next = in_ctrl;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            m_data_next = in_data;
            m_ctrl_next = in_ctrl;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: without a skid entry in_ready
            // already implies go, so an input beat always pairs with an output.
            if (SKID != 0) begin
              state_next  = FULL;
              s_data_next = in_data;
              s_ctrl_next = in_ctrl;
            end
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next  = BUSY;
            m_data_next = s_data_reg;
            m_ctrl_next = s_ctrl_reg;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Occupancy of the next cycle, so the occupancy output comes from a flop
  always_comb begin
    occupancy_next = 2'd0;
    case (state_next)
      BUSY:    occupancy_next = 2'd1;
      FULL:    occupancy_next = 2'd2;
      default: occupancy_next = 2'd0;
    endcase
  end

  // State and storage registers; reset clears everything immediately
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      m_data_reg    <= '0;
      m_ctrl_reg    <= '0;
      s_data_reg    <= '0;
      s_ctrl_reg    <= '0;
      occupancy_reg <= 2'd0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      m_data_reg    <= m_data_next;
      m_ctrl_reg    <= m_ctrl_next;
      s_data_reg    <= s_data_next;
      s_ctrl_reg    <= s_ctrl_next;
      occupancy_reg <= occupancy_next;
      in_ready_reg  <= (state_next != FULL);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg. Instance dut uses the
// default skid configuration; instance zdut is SKID=0 with 1-bit data/ctrl.
module tb_pipe_stage_reg;

  logic        clock;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [0:0]  in_ctrl;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [0:0]  out_ctrl;
  logic [1:0]  occupancy;

  logic        z_in_valid;
  logic        z_in_ready;
  logic [0:0]  z_in_data;
  logic [0:0]  z_in_ctrl;
  logic        z_stall;
  logic        z_flush;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [0:0]  z_out_data;
  logic [0:0]  z_out_ctrl;
  logic [1:0]  z_occupancy;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(1), .SKID(1)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(.DATA_W(1), .CTRL_W(1), .SKID(0)) zdut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .in_data   (z_in_data),
    .in_ctrl   (z_in_ctrl),
    .stall     (z_stall),
    .flush     (z_flush),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .out_data  (z_out_data),
    .out_ctrl  (z_out_ctrl),
    .occupancy (z_occupancy)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] q[$];
  logic [1:0] exp_beat;
  int sent;
  int recv;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    z_in_valid = 1'b0; z_in_data = '0; z_in_ctrl = '0;
    z_stall = 1'b0; z_flush = 1'b0; z_out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_z_in_ready", z_in_ready, 1);
    chk("rst_z_out_valid", z_out_valid, 0);
    #9;
    rst = 1'b0;

    // Streaming 1..8 with go=1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      in_ctrl = 1'(i % 2);
      tick();
      chk("stream_out_valid", out_valid, 1);
      chk("stream_out_data", out_data, i);
      chk("stream_out_ctrl", out_ctrl, i % 2);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_occupancy", occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_occ", occupancy, 0);

    // Stall absorb: A1 held, A2 into skid, A3 waits
    in_ctrl = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1;
    tick();
    chk("stall_a1_data", out_data, 16'h00A1);
    stall = 1'b1; in_data = 16'h00A2;
    #1;
    chk("stall_valid_held", out_valid, 1);
    tick();
    chk("stall_hold_a1", out_data, 16'h00A1);
    chk("stall_occ2", occupancy, 2);
    chk("stall_in_ready0", in_ready, 0);
    in_data = 16'h00A3;
    tick();
    chk("stall_hold2_a1", out_data, 16'h00A1);
    chk("stall_hold2_occ", occupancy, 2);
    chk("stall_hold2_rdy", in_ready, 0);
    stall = 1'b0;
    tick();
    chk("release_a2", out_data, 16'h00A2);
    chk("release_a2_occ", occupancy, 1);
    chk("release_rdy", in_ready, 1);
    tick();
    chk("release_a3", out_data, 16'h00A3);
    chk("release_a3_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("release_empty", out_valid, 0);

    // Flush while FULL, ctrl=1 on all beats
    in_ctrl = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00B1;
    tick();
    in_data = 16'h00B2;
    tick();
    chk("full_occ", occupancy, 2);
    chk("full_out_ctrl", out_ctrl, 1);
    flush = 1'b1; in_data = 16'h00B3; out_ready = 1'b1;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_after_valid", out_valid, 0);
    tick();
    chk("flush_b3_gone", out_valid, 0);

    // Flush in BUSY with in_valid and out_ready both high
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00C1;
    tick();
    chk("busy_c1", out_data, 16'h00C1);
    flush = 1'b1; in_data = 16'h00C2; out_ready = 1'b1;
    #1;
    chk("busy_flush_no_xfer", out_valid & out_ready & ~stall, 0);
    chk("busy_flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("busy_flush_occ", occupancy, 0);
    chk("busy_flush_valid", out_valid, 0);
    tick();
    chk("busy_flush_c2_gone", out_valid, 0);

    // Async reset mid-stream while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00D1;
    tick();
    in_data = 16'h00D2;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_occ", occupancy, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'h00E1; out_ready = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 16'h00E1);
    chk("post_rst_occ", occupancy, 1);
    in_valid = 1'b0;
    tick();
    chk("post_rst_drain", out_valid, 0);

    // SKID=0: out_ready toggles each cycle, 100 random beats scoreboarded
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 2000 && recv < 100; cyc++) begin
      z_out_ready = (cyc % 2 == 1);
      if (sent < 100) begin
        z_in_valid = 1'($urandom_range(0, 1));
        z_in_data  = 1'($urandom_range(0, 1));
        z_in_ctrl  = 1'($urandom_range(0, 1));
      end else begin
        z_in_valid = 1'b0;
      end
      #1;
      chk("z_out_valid", z_out_valid, (q.size() != 0));
      chk("z_in_ready", z_in_ready, (q.size() == 0) || z_out_ready);
      if (z_out_valid && z_out_ready) begin
        chk("z_beat_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_beat = q.pop_front();
          chk("z_out_data", z_out_data, exp_beat[0]);
          chk("z_out_ctrl", z_out_ctrl, exp_beat[1]);
          recv++;
        end
      end
      if (z_in_valid && z_in_ready) begin
        q.push_back({z_in_ctrl, z_in_data});
        sent++;
      end
      tick();
    end
    chk("z_recv_count", recv, 100);
    chk("z_sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed per-field stage register banks between processor stages (fetch/decode, decode/execute, and so on). It carries one packed data word plus a separately-flushable control field between two stages, with a valid/ready handshake, a stall hold, a branch flush, and an optional two-entry skid buffer. With the skid buffer, backpressure is fully registered, so long ready paths are cut at each stage boundary.

## Interface

Parameters:
- DATA_W, 16: width of the packed datapath payload (ir, pc, operands, imm, rd, mux selects).
- CTRL_W, 1: width of the control field (regwrite, memwrite, ...). It is cleared on flush and gated by valid.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clock, input, 1: the only clock; rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: the upstream stage presents a beat.
- in_ready, output, 1: the stage accepts a beat this cycle.
- in_data, input, DATA_W: payload.
- in_ctrl, input, CTRL_W: control field.
- stall, input, 1: hazard hold; freezes the output beat.
- flush, input, 1: branch taken; kills every held beat.
- out_valid, output, 1: the downstream stage sees a valid beat.
- out_ready, input, 1: the downstream stage accepts.
- out_data, output, DATA_W: payload of the head entry.
- out_ctrl, output, CTRL_W: control of the head entry, forced to 0 when out_valid=0.
- occupancy, output, 2: number of held valid entries, 0..2 (max 1 when SKID=0).

## Operation

- Storage: a head register M and, when SKID=1, a skid register S. Each holds {valid, ctrl, data}.
- Downstream acceptance: go = out_ready & !stall.
- Output signals:
  - out_valid = M.valid & !flush.
  - out_xfer = out_valid & go.
  - in_xfer = in_valid & in_ready & !flush.
- in_ready:
  - SKID=1: in_ready = !S.valid. This is a pure register output.
  - SKID=0: in_ready = !M.valid | go.
- State machine (SKID=1):
  - EMPTY (M and S empty) + in_xfer → BUSY, M ← input.
  - BUSY (M valid, S empty):
    - in_xfer & out_xfer → BUSY, M ← input.
    - in_xfer only → FULL, S ← input.
    - out_xfer only → EMPTY.
    - neither → hold.
  - FULL (M and S valid), in_ready=0:
    - out_xfer → BUSY, M ← S.
    - otherwise hold.
- SKID=0 states are EMPTY and BUSY only. BUSY + in_xfer & out_xfer → BUSY, M ← input.
- Flush:
  - Synchronous, highest priority over in and out transfers.
  - At the edge: all valids ← 0, ctrl of M and S ← 0, state → EMPTY. Data bits are not cleared.
  - A beat offered on the input during a flush cycle is dropped.
  - No output transfer occurs during a flush cycle.
- Stall:
  - M and S hold; out_data and out_ctrl are stable.
  - Input is still accepted while a free entry exists: EMPTY → BUSY, or BUSY → FULL when SKID=1.
- Ordering: beats leave in arrival order. There is no reordering, duplication or loss except on flush.
- Empty registers: data is don't-care. out_ctrl is 0 whenever out_valid=0, so bubbles never carry write enables.
- occupancy = M.valid + S.valid, registered.
- Reset (async):
  - Asserted: all valid = 0, all ctrl = 0, all data = 0.
  - Outputs during reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready during reset: 1 for SKID=1; for SKID=0 it follows the formula, giving 1.
  - Reset mid-operation discards all held beats immediately.

## Timing

- Latency: a beat accepted at edge N appears on out_* in cycle N+1. This is 1 cycle when M is empty or draining.
- Throughput: 1 beat per cycle while go=1.
- SKID=1: after go falls, one further beat is absorbed into S. in_ready falls in the cycle after S fills.
- in_ready path:
  - SKID=1: no combinational path from out_ready or stall to in_ready.
  - SKID=0: a combinational path exists.
- flush takes effect on out_valid in the same cycle (combinational) and on state at the next edge.
- rst release: first acceptance at the first rising edge with rst low.

## Test plan

- Streaming, SKID=1, go=1: beats 0x0001..0x0008 on consecutive cycles → same values out one cycle later, 8 consecutive out_valid cycles, in_ready constant 1.
- Stall absorb: stream 0xA1, 0xA2, 0xA3; raise stall after 0xA1 reaches out_data → 0xA1 held on out_data, 0xA2 taken into S, occupancy=2, in_ready=0 next cycle. On release, 0xA2 then 0xA3 emerge in order with no loss.
- Flush while FULL, in_ctrl=1 on all beats: flush for one cycle → out_valid=0 and out_ctrl=0 in the flush cycle. Next cycle occupancy=0 and in_ready=1; the beat offered during flush never appears.
- Flush with simultaneous in_valid and out_ready in BUSY → no output transfer counted, input dropped, stage EMPTY afterward.
- Async reset mid-stream: assert rst between edges while FULL → out_valid, out_ctrl and occupancy go to 0 without a clock edge; out_data=0; first beat after release passes normally.
- SKID=0, DATA_W=1, CTRL_W=1: out_ready toggling every cycle → in_ready equals !out_valid | out_ready combinationally; no beat lost or duplicated over 100 random beats checked against a scoreboard.
